// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit byte port among NR packet sources.
// Grants change only at packet boundaries; an optional header byte tags each packet's source.
module uart_tx_arbiter #(
    parameter int         NR        = 4,
    parameter bit         HEADER_EN = 1'b1,
    parameter logic [3:0] HDR_TAG   = 4'hA,
    parameter int         TIMEOUT   = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NR-1:0]         req_valid,
    input  logic [NR-1:0][7:0]    req_data,
    input  logic [NR-1:0]         req_last,
    output logic [NR-1:0]         req_ready,
    output logic                  out_valid,
    output logic [7:0]            out_data,
    input  logic                  out_ready,
    output logic [$clog2(NR)-1:0] grant_id,
    output logic                  busy,
    output logic                  timeout_err,
    output logic [15:0]           pkt_count
);

    localparam int GW = $clog2(NR);
    localparam int SW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STALL_MAX = (TIMEOUT > 0) ? SW'(TIMEOUT - 1) : '0;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_HEADER  = 2'd1;
    localparam logic [1:0] S_PAYLOAD = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [GW-1:0] last_grant_q, last_grant_d;
    logic [GW-1:0] grant_id_q, grant_id_d;
    logic [SW-1:0] stall_q, stall_d;
    logic [15:0]   pkt_count_q, pkt_count_d;

    logic [GW-1:0] win;
    logic [GW-1:0] cand;
    logic          found;
    int            idx;

    // Rotating search starting just after the last winner.
    always_comb begin
        win   = last_grant_q;
        found = 1'b0;
        cand  = '0;
        idx   = 0;
        for (int i = 1; i <= NR; i++) begin
            idx  = (int'(last_grant_q) + i) % NR;
            cand = GW'(idx);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        stall_d      = '0;
        pkt_count_d  = pkt_count_q;
        out_valid    = 1'b0;
        out_data     = '0;
        req_ready    = '0;
        timeout_err  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_id_d   = win;
                    last_grant_d = win;
                    state_d      = HEADER_EN ? S_HEADER : S_PAYLOAD;
                end
            end
            S_HEADER: begin
                out_valid = 1'b1;
                out_data  = {HDR_TAG, 4'(grant_id_q)};
                if (out_ready) begin
                    state_d = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                out_valid             = req_valid[grant_id_q];
                out_data              = req_data[grant_id_q];
                req_ready[grant_id_q] = out_ready;
                stall_d               = stall_q;
                if (req_valid[grant_id_q] && out_ready) begin
                    stall_d = '0;
                    if (req_last[grant_id_q]) begin
                        pkt_count_d = pkt_count_q + 16'd1;
                        state_d     = S_IDLE;
                    end
                end else if (!req_valid[grant_id_q]) begin
                    // Only a silent source counts as a stall, not backpressure.
                    if (TIMEOUT != 0 && stall_q == STALL_MAX) begin
                        timeout_err = 1'b1;
                        stall_d     = '0;
                        state_d     = S_IDLE;
                    end else begin
                        stall_d = stall_q + SW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= GW'(NR - 1);
            grant_id_q   <= '0;
            stall_q      <= '0;
            pkt_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            stall_q      <= stall_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

    assign grant_id = grant_id_q;
    assign busy     = (state_q != S_IDLE);
    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed vector bench for uart_tx_arbiter (NR=4, header on, TIMEOUT=8).
module tb_uart_tx_arbiter;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      req_valid;
    logic [3:0][7:0] req_data;
    logic [3:0]      req_last;
    logic [3:0]      req_ready;
    logic            out_valid;
    logic [7:0]      out_data;
    logic            out_ready;
    logic [1:0]      grant_id;
    logic            busy;
    logic            timeout_err;
    logic [15:0]     pkt_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NR(4), .HEADER_EN(1'b1), .HDR_TAG(4'hA), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err),
        .pkt_count(pkt_count)
    );

    typedef struct {
        logic [3:0]  v;
        logic [3:0]  l;
        logic        o;
        logic [31:0] d;
        logic        e_ov;
        logic [7:0]  e_od;
        logic [3:0]  e_rr;
        logic        e_busy;
        logic [1:0]  e_gid;
        logic [15:0] e_pkt;
        logic        e_te;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(
        input logic [3:0] v, input logic [3:0] l, input logic o,
        input logic [31:0] d, input logic ov, input logic [7:0] od,
        input logic [3:0] rr, input logic bz, input logic [1:0] gid,
        input logic [15:0] pkt, input logic te);
        vec_t r;
        r.v = v; r.l = l; r.o = o; r.d = d;
        r.e_ov = ov; r.e_od = od; r.e_rr = rr; r.e_busy = bz;
        r.e_gid = gid; r.e_pkt = pkt; r.e_te = te;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic drv(input logic [3:0] v, input logic [3:0] l,
                       input logic o, input logic [31:0] d);
        req_valid = v;
        req_last  = l;
        out_ready = o;
        req_data  = d;
        #2;
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        drv(4'b0, 4'b0, 1'b1, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // single requester 2: A2,11,22,33
        vt.push_back(mk(4'b0000, 4'b0000, 1, 32'h00000000, 0, 8'h00, 4'b0000, 0, 0, 0, 0));
        vt.push_back(mk(4'b0100, 4'b0000, 1, 32'h00110000, 0, 8'h00, 4'b0000, 0, 0, 0, 0));
        vt.push_back(mk(4'b0100, 4'b0000, 1, 32'h00110000, 1, 8'hA2, 4'b0000, 1, 2, 0, 0));
        vt.push_back(mk(4'b0100, 4'b0000, 1, 32'h00110000, 1, 8'h11, 4'b0100, 1, 2, 0, 0));
        vt.push_back(mk(4'b0100, 4'b0000, 1, 32'h00220000, 1, 8'h22, 4'b0100, 1, 2, 0, 0));
        vt.push_back(mk(4'b0100, 4'b0100, 1, 32'h00330000, 1, 8'h33, 4'b0100, 1, 2, 0, 0));
        vt.push_back(mk(4'b0000, 4'b0000, 1, 32'h00000000, 0, 8'h00, 4'b0000, 0, 2, 1, 0));
        // round-robin among 0,1,3 after last grant 2: 3,0,1,0
        vt.push_back(mk(4'b1011, 4'b1011, 1, 32'h53005150, 0, 8'h00, 4'b0000, 0, 2, 1, 0));
        vt.push_back(mk(4'b1011, 4'b1011, 1, 32'h53005150, 1, 8'hA3, 4'b0000, 1, 3, 1, 0));
        vt.push_back(mk(4'b1011, 4'b1011, 1, 32'h53005150, 1, 8'h53, 4'b1000, 1, 3, 1, 0));
        vt.push_back(mk(4'b0011, 4'b0011, 1, 32'h00005150, 0, 8'h00, 4'b0000, 0, 3, 2, 0));
        vt.push_back(mk(4'b0011, 4'b0011, 1, 32'h00005150, 1, 8'hA0, 4'b0000, 1, 0, 2, 0));
        vt.push_back(mk(4'b0011, 4'b0011, 1, 32'h00005150, 1, 8'h50, 4'b0001, 1, 0, 2, 0));
        vt.push_back(mk(4'b0011, 4'b0011, 1, 32'h00005160, 0, 8'h00, 4'b0000, 0, 0, 3, 0));
        vt.push_back(mk(4'b0011, 4'b0011, 1, 32'h00005160, 1, 8'hA1, 4'b0000, 1, 1, 3, 0));
        vt.push_back(mk(4'b0011, 4'b0011, 1, 32'h00005160, 1, 8'h51, 4'b0010, 1, 1, 3, 0));
        vt.push_back(mk(4'b0001, 4'b0001, 1, 32'h00000060, 0, 8'h00, 4'b0000, 0, 1, 4, 0));
        vt.push_back(mk(4'b0001, 4'b0001, 0, 32'h00000060, 1, 8'hA0, 4'b0000, 1, 0, 4, 0));
        vt.push_back(mk(4'b0001, 4'b0001, 1, 32'h00000060, 1, 8'hA0, 4'b0000, 1, 0, 4, 0));
        vt.push_back(mk(4'b0101, 4'b0001, 1, 32'h00770060, 1, 8'h60, 4'b0001, 1, 0, 4, 0));
        vt.push_back(mk(4'b0000, 4'b0000, 1, 32'h00000000, 0, 8'h00, 4'b0000, 0, 0, 5, 0));

        foreach (vt[i]) begin
            drv(vt[i].v, vt[i].l, vt[i].o, vt[i].d);
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vt[i].e_ov));
            if (vt[i].e_ov)
                chk($sformatf("v%0d out_data", i), 32'(out_data), 32'(vt[i].e_od));
            chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(vt[i].e_rr));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(vt[i].e_busy));
            chk($sformatf("v%0d grant_id", i), 32'(grant_id), 32'(vt[i].e_gid));
            chk($sformatf("v%0d pkt_count", i), 32'(pkt_count), 32'(vt[i].e_pkt));
            chk($sformatf("v%0d timeout_err", i), 32'(timeout_err), 32'(vt[i].e_te));
            nxt();
        end

        // backpressure on requester 1 for 50 cycles
        drv(4'b0010, 4'b0000, 1, 32'h00008100);
        chk("bp idle out_valid", 32'(out_valid), 32'd0);
        nxt();
        drv(4'b0010, 4'b0000, 1, 32'h00008100);
        chk("bp header", 32'(out_data), 32'hA1);
        nxt();
        drv(4'b0010, 4'b0000, 1, 32'h00008100);
        chk("bp byte0", 32'(out_data), 32'h81);
        chk("bp byte0 ready", 32'(req_ready), 32'b0010);
        nxt();
        for (int k = 0; k < 50; k++) begin
            drv(4'b0010, 4'b0000, 0, 32'h00008200);
            chk($sformatf("bp hold%0d data", k), {23'd0, out_valid, out_data}, 32'h182);
            chk($sformatf("bp hold%0d flags", k), {busy, timeout_err, req_ready}, 32'b100000);
            nxt();
        end
        drv(4'b0010, 4'b0000, 1, 32'h00008200);
        chk("bp byte1", 32'(out_data), 32'h82);
        chk("bp byte1 ready", 32'(req_ready), 32'b0010);
        nxt();
        drv(4'b0010, 4'b0010, 1, 32'h00008300);
        chk("bp byte2", 32'(out_data), 32'h83);
        nxt();
        drv(4'b0000, 4'b0000, 1, 32'h0);
        chk("bp done busy", 32'(busy), 32'd0);
        chk("bp done pkt", 32'(pkt_count), 32'd6);
        nxt();

        // timeout: requester 3 stalls after two bytes, requester 0 waiting
        drv(4'b1001, 4'b0001, 1, 32'h910000B0);
        chk("to idle", 32'(out_valid), 32'd0);
        nxt();
        drv(4'b1001, 4'b0001, 1, 32'h910000B0);
        chk("to header", 32'(out_data), 32'hA3);
        chk("to grant", 32'(grant_id), 32'd3);
        nxt();
        drv(4'b1001, 4'b0001, 1, 32'h910000B0);
        chk("to byte0", 32'(out_data), 32'h91);
        nxt();
        drv(4'b1001, 4'b0001, 1, 32'h920000B0);
        chk("to byte1", 32'(out_data), 32'h92);
        nxt();
        for (int k = 1; k <= 8; k++) begin
            drv(4'b0001, 4'b0001, 1, 32'h000000B0);
            chk($sformatf("to stall%0d err", k), 32'(timeout_err), (k == 8) ? 32'd1 : 32'd0);
            chk($sformatf("to stall%0d busy", k), {busy, out_valid}, 32'b10);
            nxt();
        end
        drv(4'b0001, 4'b0001, 1, 32'h000000B0);
        chk("to after busy", {busy, timeout_err}, 32'b00);
        chk("to after pkt", 32'(pkt_count), 32'd6);
        nxt();
        drv(4'b0001, 4'b0001, 1, 32'h000000B0);
        chk("to next header", 32'(out_data), 32'hA0);
        chk("to next grant", 32'(grant_id), 32'd0);
        nxt();
        drv(4'b0001, 4'b0001, 1, 32'h000000B0);
        chk("to next byte", 32'(out_data), 32'hB0);
        nxt();
        drv(4'b0000, 4'b0000, 1, 32'h0);
        chk("to next pkt", 32'(pkt_count), 32'd7);
        nxt();

        // reset mid-packet on requester 2
        drv(4'b0100, 4'b0100, 0, 32'h00C10000);
        nxt();
        drv(4'b0100, 4'b0100, 1, 32'h00C10000);
        chk("rs header", 32'(out_data), 32'hA2);
        nxt();
        drv(4'b0100, 4'b0100, 0, 32'h00C10000);
        chk("rs payload", {23'd0, out_valid, out_data}, 32'h1C1);
        nxt();
        rst = 1'b1;
        drv(4'b0100, 4'b0100, 1, 32'h00C10000);
        nxt();
        rst = 1'b0;
        drv(4'b0101, 4'b0101, 1, 32'h00C100D0);
        chk("rs outs", {busy, out_valid, timeout_err, req_ready}, 32'd0);
        chk("rs pkt", 32'(pkt_count), 32'd0);
        chk("rs gid", 32'(grant_id), 32'd0);
        nxt();

        // counter wrap from 16'hFFFF
        drv(4'b0101, 4'b0101, 1, 32'h00C100D0);
        chk("rs regrant header", 32'(out_data), 32'hA0);
        force dut.pkt_count_q = 16'hFFFF;
        #1;
        chk("wrap preload", 32'(pkt_count), 32'hFFFF);
        release dut.pkt_count_q;
        nxt();
        drv(4'b0101, 4'b0101, 1, 32'h00C100D0);
        chk("wrap byte", 32'(out_data), 32'hD0);
        chk("wrap before", 32'(pkt_count), 32'hFFFF);
        nxt();
        drv(4'b0100, 4'b0100, 1, 32'h00C10000);
        chk("wrap after", 32'(pkt_count), 32'd0);
        chk("wrap idle", 32'(busy), 32'd0);
        nxt();
        drv(4'b0100, 4'b0100, 1, 32'h00C10000);
        chk("fair header", 32'(out_data), 32'hA2);
        nxt();
        drv(4'b0000, 4'b0000, 1, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
